hazard_stall_controller: RTL and testbench

- Sequences stall, freeze and flush of the five-stage RV32I pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Complements operand forwarding:
  - load-use hazards that forwarding cannot cover;
  - taken-branch squash;
  - multi-cycle MUL/DIV unit (MDU) start/done handshake;
  - data-memory wait states.
- Sits beside the forwarding unit and drives the write-enable and flush inputs of every pipeline register.

---
 rtl/hazard_stall_controller.sv | 143 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard stall/freeze/flush sequencer for the five-stage RV32I pipeline.
// Arbitrates memory wait, MUL/DIV wait, branch squash and load-use bubbles.
module hazard_stall_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             branch_taken,
  input  logic             ID_EX_mdu,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_flush,
  output logic             mdu_start,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MDU_WAIT = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // Control vector, MSB first:
  // pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
  // EX_MEM_write, EX_MEM_flush, MEM_WB_flush, mdu_start
  localparam logic [8:0] CTL_ADVANCE   = 9'b110101000;
  localparam logic [8:0] CTL_MEM_FRZ   = 9'b000000010;
  localparam logic [8:0] CTL_MDU_START = 9'b000001101;
  localparam logic [8:0] CTL_MDU_HOLD  = 9'b000001100;
  localparam logic [8:0] CTL_BRANCH    = 9'b111111000;
  localparam logic [8:0] CTL_LOAD_USE  = 9'b000111000;
  localparam logic [8:0] CTL_RESET     = 9'b000000000;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [8:0]       ctl_s;
  logic [8:0]       ctl_out_s;
  logic             mem_wait_s;
  logic             load_use_s;

  // Hazard detection terms
  always_comb begin
    mem_wait_s = mem_req && !mem_ready;
    load_use_s = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                 ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
  end

  // Next-state and pipeline control selection by priority
  always_comb begin
    state_d = state_q;
    ctl_s   = CTL_ADVANCE;
    case (state_q)
      ST_MDU_WAIT: begin
        // A memory freeze stalls the MDU wait in place; the MDU is not restarted.
        if (mem_wait_s) begin
          ctl_s   = CTL_MEM_FRZ;
          state_d = ST_MDU_WAIT;
        end else if (mdu_done) begin
          ctl_s   = CTL_ADVANCE;
          state_d = ST_RUN;
        end else begin
          ctl_s   = CTL_MDU_HOLD;
          state_d = ST_MDU_WAIT;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        // The release cycle of a memory wait arbitrates exactly like RUN.
        if (mem_wait_s) begin
          ctl_s   = CTL_MEM_FRZ;
          state_d = ST_MEM_WAIT;
        end else if (ID_EX_mdu) begin
          ctl_s   = CTL_MDU_START;
          state_d = ST_MDU_WAIT;
        end else if (branch_taken) begin
          ctl_s   = CTL_BRANCH;
          state_d = ST_RUN;
        end else if (load_use_s) begin
          ctl_s   = CTL_LOAD_USE;
          state_d = ST_RUN;
        end else begin
          ctl_s   = CTL_ADVANCE;
          state_d = ST_RUN;
        end
      end
      default: begin
        ctl_s   = CTL_MEM_FRZ;
        state_d = ST_RUN;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted
  always_comb begin
    if (rst_n) begin
      ctl_out_s = ctl_s;
    end else begin
      ctl_out_s = CTL_RESET;
    end
  end

  assign pc_write     = ctl_out_s[8];
  assign IF_ID_write  = ctl_out_s[7];
  assign IF_ID_flush  = ctl_out_s[6];
  assign ID_EX_write  = ctl_out_s[5];
  assign ID_EX_flush  = ctl_out_s[4];
  assign EX_MEM_write = ctl_out_s[3];
  assign EX_MEM_flush = ctl_out_s[2];
  assign MEM_WB_flush = ctl_out_s[1];
  assign mdu_start    = ctl_out_s[0];

  // Saturating count of cycles in which the PC is held
  always_comb begin
    if (!ctl_out_s[8] && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  assign stall_count = stall_count_q;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      stall_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: reference model pushes
// expected controls and counter values, DUT observations are popped and compared.
module tb_hazard_stall_controller;

  logic        clk;
  logic        rst_n;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_rd;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
  logic        branch_taken;
  logic        ID_EX_mdu;
  logic        mdu_done;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
  logic        EX_MEM_write, EX_MEM_flush, MEM_WB_flush, mdu_start;
  logic [31:0] stall_count;
  logic        pc_write4, IF_ID_write4, IF_ID_flush4, ID_EX_write4, ID_EX_flush4;
  logic        EX_MEM_write4, EX_MEM_flush4, MEM_WB_flush4, mdu_start4;
  logic [3:0]  stall_count4;

  int checks;
  int errors;

  logic [8:0]  exp_ctl_q[$];
  logic [31:0] exp_cnt_q[$];
  logic [3:0]  exp_cnt4_q[$];

  // Reference model state: 0 RUN, 1 MDU_WAIT, 2 MEM_WAIT
  int          m_st;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  localparam logic [8:0] E_ADV   = 9'b110101000;
  localparam logic [8:0] E_MEM   = 9'b000000010;
  localparam logic [8:0] E_MDUS  = 9'b000001101;
  localparam logic [8:0] E_MDUH  = 9'b000001100;
  localparam logic [8:0] E_BR    = 9'b111111000;
  localparam logic [8:0] E_LU    = 9'b000111000;
  localparam logic [8:0] E_ZERO  = 9'b000000000;

  hazard_stall_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .branch_taken(branch_taken), .ID_EX_mdu(ID_EX_mdu), .mdu_done(mdu_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_write(EX_MEM_write), .EX_MEM_flush(EX_MEM_flush),
    .MEM_WB_flush(MEM_WB_flush), .mdu_start(mdu_start),
    .stall_count(stall_count)
  );

  hazard_stall_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .branch_taken(branch_taken), .ID_EX_mdu(ID_EX_mdu), .mdu_done(mdu_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write4), .IF_ID_write(IF_ID_write4), .IF_ID_flush(IF_ID_flush4),
    .ID_EX_write(ID_EX_write4), .ID_EX_flush(ID_EX_flush4),
    .EX_MEM_write(EX_MEM_write4), .EX_MEM_flush(EX_MEM_flush4),
    .MEM_WB_flush(MEM_WB_flush4), .mdu_start(mdu_start4),
    .stall_count(stall_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_ctl();
    return {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
            EX_MEM_write, EX_MEM_flush, MEM_WB_flush, mdu_start};
  endfunction

  function automatic logic [8:0] dut4_ctl();
    return {pc_write4, IF_ID_write4, IF_ID_flush4, ID_EX_write4, ID_EX_flush4,
            EX_MEM_write4, EX_MEM_flush4, MEM_WB_flush4, mdu_start4};
  endfunction

  // Expected controls and next model state from the current inputs
  task automatic model(output logic [8:0] ctl, output int nxt);
    logic mw, lu;
    mw  = mem_req && !mem_ready;
    lu  = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
          ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
    nxt = 0;
    if (!rst_n) begin
      ctl = E_ZERO;
    end else if (mw) begin
      ctl = E_MEM;
      nxt = (m_st == 1) ? 1 : 2;
    end else if (m_st == 1) begin
      ctl = mdu_done ? E_ADV : E_MDUH;
      nxt = mdu_done ? 0 : 1;
    end else if (ID_EX_mdu) begin
      ctl = E_MDUS;
      nxt = 1;
    end else if (branch_taken) begin
      ctl = E_BR;
    end else if (lu) begin
      ctl = E_LU;
    end else begin
      ctl = E_ADV;
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic mdu,
                       input logic done, input logic mreq, input logic mrdy);
    ID_EX_MemRead = mr;  ID_EX_rd = rd;  IF_ID_rs1 = rs1;  IF_ID_rs2 = rs2;
    branch_taken = br;   ID_EX_mdu = mdu; mdu_done = done;
    mem_req = mreq;      mem_ready = mrdy;
  endtask

  // One pipeline cycle: drive at negedge, check controls, clock, check counters
  task automatic cyc(input string tag, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                     input logic mdu, input logic done, input logic mreq, input logic mrdy);
    logic [8:0] ectl;
    int         nxt;
    @(negedge clk);
    drive(mr, rd, rs1, rs2, br, mdu, done, mreq, mrdy);
    #1;
    model(ectl, nxt);
    exp_ctl_q.push_back(ectl);
    exp_ctl_q.push_back(ectl);
    check_val({tag, "_ctl"}, {23'd0, dut_ctl()}, {23'd0, exp_ctl_q.pop_front()});
    check_val({tag, "_ctl4"}, {23'd0, dut4_ctl()}, {23'd0, exp_ctl_q.pop_front()});
    @(posedge clk);
    if (rst_n) begin
      m_st = nxt;
      if (!ectl[8]) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
      end
    end
    exp_cnt_q.push_back(m_cnt);
    exp_cnt4_q.push_back(m_cnt4);
    #1;
    check_val({tag, "_cnt"}, stall_count, exp_cnt_q.pop_front());
    check_val({tag, "_cnt4"}, {28'd0, stall_count4}, {28'd0, exp_cnt4_q.pop_front()});
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_st   = 0;
    m_cnt  = 32'd0;
    m_cnt4 = 4'd0;
    rst_n  = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #2;
    check_val("rst_ctl", {23'd0, dut_ctl()}, {23'd0, E_ZERO});
    check_val("rst_cnt", stall_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("run_idle");

    // Load-use: one bubble, then the hazard clears
    cyc("lu_rs1", 1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("lu_after");
    cyc("lu_rs2", 1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_x0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_nold", 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_nomatch", 1'b1, 5'd7, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch overrides load-use
    cyc("br_lu", 1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // MDU: start pulse, three further held cycles, then done
    cyc("mdu_start", 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("mdu_wait", 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mdu_done", 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("mdu_done_run", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Memory wait with pending branch, serviced on release
    for (int i = 0; i < 3; i++)
      cyc("mem_wait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mem_rel_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("mem_after");

    // Memory wait pending MDU starts on release
    cyc("mem_mdu", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("mem_mdu_rel", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    // Memory freeze inside MDU wait, then done once the freeze lifts
    cyc("mdu_memw", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("mdu_brhold", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("mdu_done2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("mdu_after2");

    // Reset in the second cycle of an MDU wait
    cyc("rmdu_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("rmdu_wait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    m_st = 0;  m_cnt = 32'd0;  m_cnt4 = 4'd0;
    #1;
    check_val("rmid_ctl", {23'd0, dut_ctl()}, {23'd0, E_ZERO});
    check_val("rmid_cnt", stall_count, 32'd0);
    check_val("rmid_cnt4", {28'd0, stall_count4}, 32'd0);
    cyc("rhold", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle("rrel");

    // Saturation: 20 frozen cycles, the 4-bit counter sticks at 15
    for (int i = 0; i < 20; i++)
      cyc("sat", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("sat_cnt4", {28'd0, stall_count4}, 32'd15);
    check_val("sat_cnt", stall_count, 32'd20);
    cyc("sat_rel", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
